// File: rtl/prog_fetch_seq_if.sv
`default_nettype none
// ============================================================================
// prog_fetch_seq_if : ROM bus plus instruction valid/ready handshake
// Rev 1.0
// ============================================================================
interface prog_fetch_seq_if #(
  parameter int INSTR_BYTES = 4
);
  logic [7:0]               rom_addr;
  logic [7:0]               rom_data;
  logic [8*INSTR_BYTES-1:0] instr;
  logic [7:0]               instr_pc;
  logic                     instr_valid;
  logic                     instr_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/prog_fetch_seq.sv
`default_nettype none
// ============================================================================
// prog_fetch_seq : fetches INSTR_BYTES ROM bytes per word, double-buffered
// Rev 1.0
// ============================================================================
module prog_fetch_seq #(
  parameter int         INSTR_BYTES = 4,
  parameter logic [7:0] RESET_PC    = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             jump_i,
  input  logic [7:0]       jump_target_i,
  prog_fetch_seq_if.master fetch_if
);

  localparam int               WORD_W   = 8 * INSTR_BYTES;
  localparam int               LOW_W    = 8 * (INSTR_BYTES - 1);
  localparam int               CNT_W    = $clog2(INSTR_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e              state_q,       state_d;
  logic [7:0]          fetch_ptr_q,   fetch_ptr_d;
  logic [CNT_W-1:0]    issue_cnt_q,   issue_cnt_d;
  logic [CNT_W-1:0]    cap_cnt_q,     cap_cnt_d;
  logic                inflight_q,    inflight_d;
  logic [WORD_W-1:0]   asm_q,         asm_d;
  logic [7:0]          asm_pc_q,      asm_pc_d;
  logic [WORD_W-1:0]   instr_q,       instr_d;
  logic [7:0]          instr_pc_q,    instr_pc_d;
  logic                instr_valid_q, instr_valid_d;

  logic                w_issue;
  logic                w_accept;
  logic                w_out_free;
  logic [WORD_W-1:0]   w_last_word;

  assign w_issue     = (state_q == ST_ISSUE) && en_i;
  assign w_accept    = instr_valid_q && fetch_if.instr_ready;
  assign w_out_free  = !instr_valid_q || fetch_if.instr_ready;
  // In DRAIN the final byte is still on rom_data, not yet in the buffer.
  assign w_last_word = {fetch_if.rom_data, asm_q[LOW_W-1:0]};

  always_comb begin
    state_d       = state_q;
    fetch_ptr_d   = fetch_ptr_q;
    issue_cnt_d   = issue_cnt_q;
    cap_cnt_d     = cap_cnt_q;
    inflight_d    = w_issue;
    asm_d         = asm_q;
    asm_pc_d      = asm_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (inflight_q) begin
      asm_d[8*cap_cnt_q +: 8] = fetch_if.rom_data;
      cap_cnt_d               = cap_cnt_q + CNT_W'(1);
    end

    if (w_accept) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      ST_ISSUE: begin
        if (w_issue) begin
          fetch_ptr_d = fetch_ptr_q + 8'd1;
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == '0) begin
            asm_pc_d = fetch_ptr_q;
          end
          if (issue_cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_out_free) begin
          instr_d       = w_last_word;
          instr_pc_d    = asm_pc_q;
          instr_valid_d = 1'b1;
          issue_cnt_d   = '0;
          cap_cnt_d     = '0;
          state_d       = ST_ISSUE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_accept) begin
          instr_d       = asm_q;
          instr_pc_d    = asm_pc_q;
          instr_valid_d = 1'b1;
          issue_cnt_d   = '0;
          cap_cnt_d     = '0;
          state_d       = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase

    // A redirect overrides everything, including a load on this edge.
    if (jump_i) begin
      fetch_ptr_d   = jump_target_i;
      state_d       = ST_ISSUE;
      issue_cnt_d   = '0;
      cap_cnt_d     = '0;
      inflight_d    = 1'b0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ISSUE;
      fetch_ptr_q   <= RESET_PC;
      issue_cnt_q   <= '0;
      cap_cnt_q     <= '0;
      inflight_q    <= 1'b0;
      asm_q         <= '0;
      asm_pc_q      <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_ptr_q   <= fetch_ptr_d;
      issue_cnt_q   <= issue_cnt_d;
      cap_cnt_q     <= cap_cnt_d;
      inflight_q    <= inflight_d;
      asm_q         <= asm_d;
      asm_pc_q      <= asm_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign fetch_if.rom_addr    = fetch_ptr_q;
  assign fetch_if.instr       = instr_q;
  assign fetch_if.instr_pc    = instr_pc_q;
  assign fetch_if.instr_valid = instr_valid_q;

endmodule
`default_nettype wire

// File: doc/prog_fetch_seq.md
Name: prog_fetch_seq

Overview:
- Instruction-fetch sequencer for the 8-bit-wide, registered-output program ROM (1-cycle read latency, 8-bit address).
- Generates ROM addresses and collects INSTR_BYTES consecutive bytes into one instruction word.
- Presents the word to the decode/execute stage over a valid/ready handshake, and redirects on jumps.
- Double-buffered: one assembly buffer and one output register.

Parameters:
- INSTR_BYTES, 4, bytes per instruction (2..8).
- RESET_PC, 8'h00, fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable; 0 suppresses new ROM address issue.
- rom_addr  out  8  address to ROM; registered; equals the fetch pointer.
- rom_data  in  8  ROM output; holds the byte for the address the ROM sampled at the previous edge.
- jump  in  1  single-cycle redirect request.
- jump_target  in  8  new fetch address, sampled when jump=1.
- instr  out  8*INSTR_BYTES  assembled instruction; byte k (from address pc+k) at bits [8k+7:8k].
- instr_pc  out  8  address of byte 0 of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  consumer accepts when instr_valid and instr_ready are both 1 at an edge.

Behaviour:
- Reset (async):
  - fetch_ptr=RESET_PC; state=ISSUE; issue_cnt=0; cap_cnt=0; inflight=0.
  - instr=0; instr_pc=0; instr_valid=0; assembly buffer=0.
- Issue timing: a byte is "issued" in cycle c when state=ISSUE and en=1.
  - ROM samples rom_addr at the end of c; rom_data is captured at the end of c+1.
  - inflight is a 1-bit flag marking that rom_data is valid this cycle.
- ISSUE state, on each issue:
  - fetch_ptr += 1 (8-bit wrap, 0xFF -> 0x00; instructions may straddle the wrap).
  - issue_cnt += 1.
  - On the first issue, record fetch_ptr as asm_pc.
  - When issue_cnt reaches INSTR_BYTES-1 and an issue occurs, go to DRAIN.
- Capture: whenever inflight=1, write rom_data into assembly byte cap_cnt and increment cap_cnt.
- DRAIN: one cycle, no issue; the last byte is captured at the end of this cycle.
  - If the output register is free at that edge (instr_valid=0, or instr_valid&instr_ready), load instr<=assembly with last byte, instr_pc<=asm_pc, instr_valid<=1, and go to ISSUE with counters cleared.
  - Otherwise go to HOLD.
- HOLD: no issue. When instr_valid&instr_ready, load the output register from the assembly buffer (instr_valid stays 1) and go to ISSUE.
- Output handshake:
  - instr_valid&instr_ready with no new load -> instr_valid<=0.
  - instr and instr_pc stay stable while instr_valid=1 and not accepted.
- Throughput: one instruction per INSTR_BYTES+1 cycles when instr_ready=1 and en=1.
- en=0 in ISSUE: no issue, fetch_ptr holds, the in-flight byte is still captured, state holds. en has no effect in DRAIN or HOLD.
- jump=1 (highest priority, any state):
  - fetch_ptr<=jump_target; state<=ISSUE; issue_cnt, cap_cnt, inflight <=0; partial assembly discarded.
  - instr_valid<=0, even if a handshake completes in the same cycle; that accept still counts as consumed.
  - No DRAIN/HOLD load happens on that edge.
  - First issue from jump_target is in the next cycle.
- Back-to-back jumps: the last one wins.
- rst mid-operation: all state returns to reset values immediately.

Test Plan:
- ROM mem[i]=i+0x10, INSTR_BYTES=4, reset released before edge 0, en=1, instr_ready=1 -> rom_addr=0,1,2,3 in cycles 0-3; instr_valid=1 in cycle 5 with instr=0x13121110, instr_pc=0x00; next instr=0x17161514, pc=0x04 valid in cycle 10.
- instr_ready=0 for 20 cycles -> first word held stable; second word assembled, state HOLD, rom_addr stays 0x08; on the ready pulse the second word appears next cycle with instr_pc=0x04.
- jump=1, jump_target=0x40 during cycle 2 of an assembly -> partial word discarded, instr_valid=0; rom_addr=0x40 next cycle; next instr=0x53525150, pc=0x40.
- jump_target=0xFE -> instr=0x11100F0E (bytes mem[FE],mem[FF],mem[00],mem[01]), instr_pc=0xFE.
- en toggled 1,0,1,0 during ISSUE -> no byte skipped or duplicated; word content identical to the en=1 case, only delayed.
- rst asserted in DRAIN with instr_valid=1 -> instr_valid=0, rom_addr=RESET_PC immediately; after release the fetch restarts from RESET_PC.
